// File: rtl/serial_addsub_fsm_if.sv
// Parallel operand/command side and serial/parallel result side of the bit-serial adder/subtractor.
// master drives operands and start; slave (the datapath) drives status and results.
interface serial_addsub_fsm_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             busy;
    logic             sum_out;
    logic             sum_valid;
    logic             a_bit;
    logic             b_bit;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             done;

    modport master (
        output start, sub, data_a, data_b,
        input  busy, sum_out, sum_valid, a_bit, b_bit, result, carry_out, overflow, done
    );

    modport slave (
        input  start, sub, data_a, data_b,
        output busy, sum_out, sum_valid, a_bit, b_bit, result, carry_out, overflow, done
    );
endinterface

// File: rtl/serial_addsub_fsm.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, with IDLE/SHIFT/DONE control.
// Latency: start edge to done is WIDTH+1 cycles; start is ignored while busy (no queueing).
module serial_addsub_fsm #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_addsub_fsm_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sra_q, sra_d;
    logic [WIDTH-1:0] srb_q, srb_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic b_eff;
    logic sum_bit;
    logic carry_nxt;

    // Subtract is A + ~B + 1: B is inverted per bit and the +1 is the preloaded carry.
    assign b_eff     = srb_q[0] ^ mode_q;
    assign sum_bit   = sra_q[0] ^ b_eff ^ carry_q;
    assign carry_nxt = (sra_q[0] & b_eff) | (sra_q[0] & carry_q) | (b_eff & carry_q);

    always_comb begin
        state_d     = state_q;
        sra_d       = sra_q;
        srb_d       = srb_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_SHIFT;
                    sra_d       = bus.data_a;
                    srb_d       = bus.data_b;
                    mode_d      = bus.sub;
                    carry_d     = bus.sub;
                    cnt_d       = '0;
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            S_SHIFT: begin
                carry_d  = carry_nxt;
                sra_d    = {1'b0, sra_q[WIDTH-1:1]};
                srb_d    = {1'b0, srb_q[WIDTH-1:1]};
                result_d = {sum_bit, result_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    carry_out_d = carry_nxt;
                    // carry_q here is the carry into the MSB position
                    overflow_d  = carry_q ^ carry_nxt;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sra_q       <= '0;
            srb_q       <= '0;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sra_q       <= sra_d;
            srb_q       <= srb_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.sum_valid = (state_q == S_SHIFT);
    assign bus.sum_out   = (state_q == S_SHIFT) & sum_bit;
    assign bus.a_bit     = sra_q[0];
    assign bus.b_bit     = srb_q[0];
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: doc/serial_addsub_fsm.md
# serial_addsub_fsm

Parametrised bit-serial adder/subtractor with an integrated control FSM, the WIDTH-generic successor to the fixed 8-bit serial full-adder datapath. It captures two parallel WIDTH-bit operands on `start` and processes them LSB-first, one bit per clock. It streams the sum/difference serially, assembles the parallel result, and reports carry, signed overflow and completion. It sits between a parallel register interface and serial consumers (LEDs, UART tx, further serial arithmetic).

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin operation; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; sampled with `start`.
- data_a  input  WIDTH  operand A; sampled with `start`.
- data_b  input  WIDTH  operand B; sampled with `start`.
- busy  output  1  high in SHIFT and DONE.
- sum_out  output  1  current serial sum bit; meaningful only while `sum_valid`=1.
- sum_valid  output  1  high during each of the WIDTH SHIFT cycles.
- a_bit  output  1  LSB of the A shift register.
- b_bit  output  1  LSB of the B shift register (raw B, not inverted).
- result  output  WIDTH  parallel result; valid from DONE until the next accepted `start`.
- carry_out  output  1  final carry; for subtract, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow of the final result.
- done  output  1  single-cycle pulse in DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT on `start`=1:
  - sra ← data_a, srb ← data_b, mode ← sub.
  - carry ← sub, bit counter ← 0.
  - result ← 0, carry_out ← 0, overflow ← 0.
- SHIFT, combinational outputs:
  - b_eff = srb[0] ^ mode.
  - sum_out = sra[0] ^ b_eff ^ carry.
- SHIFT, at each edge:
  - carry ← majority(sra[0], b_eff, carry).
  - sra and srb shift right with zero fill.
  - result shifts right, with sum_out entering at the MSB.
  - counter increments.
- When counter = WIDTH−1:
  - Next state is DONE.
  - carry_out ← new carry.
  - overflow ← (carry entering the MSB) ^ (new carry).
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` in SHIFT or DONE is ignored. It is not queued, and `sub`/`data_*` changes have no effect.
- result, carry_out and overflow hold their values in IDLE until the next accepted `start`.
- After a full operation, sra and srb are all zero, so a_bit = b_bit = 0 in DONE and in IDLE.
- Arithmetic is modulo 2^WIDTH.
  - carry_out is bit WIDTH of A + B (add) or of A + ~B + 1 (subtract).
  - overflow follows standard signed rules.

## Timing
- Edge E0 accepts `start`.
- Cycles E0..E(WIDTH−1): SHIFT, with sum_valid=1. Bit i of the result appears on sum_out in the cycle after edge Ei.
- Cycle after E(WIDTH): DONE. done=1; result, carry_out and overflow are already final.
- Edge E(WIDTH+1): IDLE. The earliest next `start` is accepted at E(WIDTH+2).
- Total latency from the `start` edge to `done`: WIDTH+1 cycles. busy is high for WIDTH+1 cycles.
- Reset (rst=0 at any edge, including mid-SHIFT):
  - State goes to IDLE.
  - All registers clear, so every output is 0.
  - The aborted operation produces no `done`.
- Reset dominates `start` at the same edge.

## Test plan
- WIDTH=8, add 0x3C+0x5A:
  - sum_out sequence LSB-first 0,1,1,0,1,0,0,1.
  - result=0x96, carry_out=0, overflow=1.
  - done exactly 9 cycles after the start edge.
- WIDTH=8, add 0xFF+0x01 → result=0x00, carry_out=1, overflow=0.
- WIDTH=8, subtract:
  - 0x05−0x07 → result=0xFE, carry_out=0, overflow=0.
  - 0x80−0x01 → result=0x7F, carry_out=1, overflow=1.
- Start while busy:
  - Pulse start with new operands at cycles 3 and 8 of an operation → first result is unaffected, no second operation runs.
  - start at E(WIDTH+2) is accepted normally.
- Reset mid-operation:
  - Drive rst=0 at the 4th SHIFT cycle → next cycle has all outputs 0 and state IDLE, with no done pulse.
  - A following add 0x01+0x01 gives result=0x02.
- WIDTH=16, add 0xFFFF+0x0001 → result=0x0000, carry_out=1, done 17 cycles after start. Repeat with a randomised sweep of 1000 add/sub pairs checked against a reference model.
